accel_operand_fetch: RTL and testbench

ACCEL_OPERAND_FETCH -- requirements
Module: accel_operand_fetch

---
 rtl/accel_operand_fetch.sv | 153 +++++++++++++++
 tb/tb_accel_operand_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_operand_fetch.sv
// Operand-pair fetch: issues paired weight/input reads, tracks fixed-latency returns
// and queues the pairs in a credit-protected FIFO for the MAC consumer.
module accel_operand_fetch #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] Waddress_current,
  input  logic [ADDR_W-1:0] Inaddress_current,
  output logic              req_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [ADDR_W-1:0] in_mem_addr,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] w_mem_rdata,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic [DATA_W-1:0] W_data,
  output logic [DATA_W-1:0] In_data,
  output logic              DVAL,
  input  logic              Enable,
  input  logic              flush,
  output logic              busy
);

  localparam int STAGES = MEM_LAT - 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 3;
  localparam int FC_W   = 3;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] x;
  } pair_t;

  state_t            state, state_nxt;
  logic [FC_W-1:0]   fl_cnt, fl_cnt_nxt;
  logic [STAGES:0]   vld_pipe;
  pair_t             fifo_mem [DEPTH];
  pair_t             head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  inflight, occupancy;
  logic              accept, push, pop, clr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + SUM_W'(vld_pipe[i]);
  end

  // Credits count both queued and in-flight pairs so a return can never find the FIFO full.
  assign occupancy   = SUM_W'(fifo_count) + inflight;
  assign req_ready   = (state == ACTIVE) && !mem_stall && !flush && (occupancy < SUM_W'(DEPTH));
  assign accept      = req_valid & req_ready;
  assign mem_rd_en   = accept;
  assign w_mem_addr  = Waddress_current;
  assign in_mem_addr = Inaddress_current;

  assign clr  = flush || (state == FLUSH);
  assign push = vld_pipe[STAGES] && !clr;
  assign DVAL = (fifo_count != '0);
  assign pop  = DVAL && Enable && !clr;
  assign busy = (fifo_count != '0) || (|vld_pipe);

  assign head    = fifo_mem[rd_ptr];
  assign W_data  = DVAL ? head.w : '0;
  assign In_data = DVAL ? head.x : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Read data is captured on the edge where its valid bit leaves the last stage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{w: w_mem_rdata, x: in_mem_rdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      fl_cnt <= '0;
    end else begin
      state  <= state_nxt;
      fl_cnt <= fl_cnt_nxt;
    end
  end

  // FLUSH exits only after MEM_LAT consecutive cycles with flush low.
  always_comb begin
    state_nxt  = state;
    fl_cnt_nxt = fl_cnt;
    case (state)
      IDLE: begin
        state_nxt  = ACTIVE;
        fl_cnt_nxt = '0;
      end
      ACTIVE: begin
        if (flush) begin
          state_nxt  = FLUSH;
          fl_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        if (flush) begin
          fl_cnt_nxt = '0;
        end else if (fl_cnt == FC_W'(MEM_LAT - 1)) begin
          state_nxt  = ACTIVE;
          fl_cnt_nxt = '0;
        end else begin
          fl_cnt_nxt = fl_cnt + FC_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        fl_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_accel_operand_fetch.sv
// Bench for accel_operand_fetch: fixed-latency memory emulator plus a queue-based
// reference model checked every cycle, with directed scenarios and a random phase.
module tb_accel_operand_fetch;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 2;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] Waddress_current = '0;
  logic [ADDR_W-1:0] Inaddress_current = '0;
  logic              req_ready, mem_rd_en;
  logic [ADDR_W-1:0] w_mem_addr, in_mem_addr;
  logic              mem_stall = 1'b0;
  logic [DATA_W-1:0] w_mem_rdata, in_mem_rdata;
  logic [DATA_W-1:0] W_data, In_data;
  logic              DVAL;
  logic              Enable = 1'b0;
  logic              flush = 1'b0;
  logic              busy;

  accel_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .Waddress_current(Waddress_current), .Inaddress_current(Inaddress_current),
    .req_ready(req_ready), .mem_rd_en(mem_rd_en),
    .w_mem_addr(w_mem_addr), .in_mem_addr(in_mem_addr), .mem_stall(mem_stall),
    .w_mem_rdata(w_mem_rdata), .in_mem_rdata(in_mem_rdata),
    .W_data(W_data), .In_data(In_data), .DVAL(DVAL),
    .Enable(Enable), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] x;
  } pair_t;

  typedef struct {
    pair_t p;
    int    due;
  } flight_t;

  function automatic pair_t mem_pair(input logic [15:0] wa, input logic [15:0] ia);
    pair_t r;
    r.w = {wa[7:0], wa[15:8]} ^ 16'h0F0F;
    r.x = ia + 16'h1234;
    return r;
  endfunction

  // Memory emulator: data for a strobe in cycle c is presented during cycle c+MEM_LAT.
  logic [15:0] wa_pipe [MEM_LAT];
  logic [15:0] ia_pipe [MEM_LAT];
  pair_t       rd_pair;

  always @(posedge clk) begin
    wa_pipe[0] <= w_mem_addr;
    ia_pipe[0] <= in_mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      wa_pipe[i] <= wa_pipe[i-1];
      ia_pipe[i] <= ia_pipe[i-1];
    end
  end

  always_comb rd_pair = mem_pair(wa_pipe[MEM_LAT-1], ia_pipe[MEM_LAT-1]);
  assign w_mem_rdata  = rd_pair.w;
  assign in_mem_rdata = rd_pair.x;

  // Reference model: queued pairs, in-flight pairs with due cycle, mode 0 idle / 1 active / 2 flush.
  pair_t   fifo_q [$];
  flight_t fly_q  [$];
  int      cyc = 0;
  int      mode = 0;
  int      quiet = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic        last_acc, last_dval, last_ready;
  logic [15:0] last_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    fly_q.delete();
    mode  = 0;
    quiet = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rden"},  mem_rd_en, 0);
    chk({tag, "_dval"},  DVAL, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_wdata"}, W_data, 0);
    chk({tag, "_indata"}, In_data, 0);
  endtask

  // One clock: drive, check at negedge against the model, advance the model, step to posedge+1.
  task automatic cycle(input logic rv, input logic [15:0] wa, input logic [15:0] ia,
                       input logic st, input logic en, input logic fl);
    pair_t   head;
    flight_t f;
    logic    exp_ready, exp_dval;
    req_valid = rv; Waddress_current = wa; Inaddress_current = ia;
    mem_stall = st; Enable = en; flush = fl;
    @(negedge clk);
    exp_ready = (mode == 1) && !st && !fl && ((fifo_q.size() + fly_q.size()) < DEPTH);
    exp_dval  = (fifo_q.size() != 0);
    head      = exp_dval ? fifo_q[0] : '0;
    chk("req_ready", req_ready, exp_ready);
    chk("mem_rd_en", mem_rd_en, rv && exp_ready);
    chk("w_addr", w_mem_addr, wa);
    chk("in_addr", in_mem_addr, ia);
    chk("dval", DVAL, exp_dval);
    chk("w_data", W_data, head.w);
    chk("in_data", In_data, head.x);
    chk("busy", busy, (fifo_q.size() + fly_q.size()) != 0);
    last_acc = mem_rd_en; last_dval = DVAL; last_ready = req_ready; last_w = W_data;
    if (fl || mode == 2) begin
      fifo_q.delete();
      fly_q.delete();
    end else begin
      if (exp_dval && en) void'(fifo_q.pop_front());
      if (fly_q.size() != 0 && fly_q[0].due == cyc) begin
        f = fly_q.pop_front();
        fifo_q.push_back(f.p);
      end
      if (exp_ready && rv) begin
        f.p = mem_pair(wa, ia);
        f.due = cyc + MEM_LAT;
        fly_q.push_back(f);
      end
    end
    case (mode)
      0: mode = 1;
      1: if (fl) begin mode = 2; quiet = 0; end
      default: begin
        if (fl) quiet = 0;
        else begin
          quiet++;
          if (quiet == MEM_LAT) mode = 1;
        end
      end
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int lat, cnt, lows, pops, acc, chg, idx, k;
    logic [15:0] ref_w;
    logic seen;

    model_reset();
    #2;
    chk_reset_outputs("rst_init");
    @(posedge clk); #1;
    chk_reset_outputs("rst_hold");
    rst = 1'b1;
    model_reset();
    idle_cycles(1);

    // Single request: one strobe, DVAL MEM_LAT+1 cycles later for exactly one cycle.
    cycle(1'b1, 16'h1111, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("single_acc", last_acc, 1);
    lat = -1; cnt = 0; acc = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      acc += int'(last_acc);
      if (last_dval) begin
        cnt++;
        if (lat < 0) lat = i;
        chk("single_w", last_w, mem_pair(16'h1111, 16'h0).w);
      end
    end
    chk("single_lat", lat, MEM_LAT + 1);
    chk("single_dval_cycles", cnt, 1);
    chk("single_extra_strobe", acc, 0);

    // Back-to-back stream of 16 requests with the consumer always ready.
    lows = 0; pops = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 16'h1111 + 16'(i), 16'(i), 1'b0, 1'b1, 1'b0);
      if (!last_ready) lows++;
      if (last_dval) pops++;
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      if (last_dval) pops++;
    end
    chk("stream_ready_low", lows, 0);
    chk("stream_pairs", pops, 16);

    // Consumer stalled: only DEPTH requests fit, head stays put, then resumes cleanly.
    idx = 0; acc = 0; chg = 0; seen = 1'b0; ref_w = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'h2000 + 16'(idx), 16'h3000 + 16'(idx), 1'b0, 1'b0, 1'b0);
      if (last_acc) begin idx++; acc++; end
      if (last_dval && !seen) begin seen = 1'b1; ref_w = last_w; end
      else if (seen && last_w != ref_w) chg++;
    end
    chk("bp_accepts", acc, DEPTH);
    chk("bp_ready_low", last_ready, 0);
    chk("bp_w_stable", chg, 0);
    k = 0;
    while (idx < 12 && k < 40) begin
      cycle(1'b1, 16'h2000 + 16'(idx), 16'h3000 + 16'(idx), 1'b0, 1'b1, 1'b0);
      if (last_acc) idx++;
      k++;
    end
    chk("bp_resume", idx, 12);
    idle_cycles(8);

    // Memory stall with two reads in flight.
    cycle(1'b1, 16'h4000, 16'h5000, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h4001, 16'h5001, 1'b0, 1'b1, 1'b0);
    acc = 0; pops = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h4002, 16'h5002, 1'b1, 1'b1, 1'b0);
      acc += int'(last_acc);
      if (last_dval) pops++;
    end
    chk("stall_strobes", acc, 0);
    chk("stall_returns", pops, 2);
    idx = 2; k = 0;
    while (idx < 8 && k < 30) begin
      cycle(1'b1, 16'h4000 + 16'(idx), 16'h5000 + 16'(idx), 1'b0, 1'b1, 1'b0);
      if (last_acc) idx++;
      k++;
    end
    chk("stall_resume", idx, 8);
    idle_cycles(6);

    // Flush with three queued and one in flight.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h6000 + 16'(i), 16'h7000 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h6100, 16'h7100, 1'b0, 1'b1, 1'b1);
    chk("flush_dval", last_dval, 0);
    chk("flush_ready", last_ready, 0);
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 16'h6200 + 16'(i), 16'h7200 + 16'(i), 1'b0, 1'b1, 1'b0);
      if (last_ready && lat < 0) lat = i;
    end
    chk("flush_ready_delay", lat, MEM_LAT);
    idle_cycles(6);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h8000 + 16'(i), 16'h9000 + 16'(i), 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("rst_async");
    @(posedge clk); #1;
    chk_reset_outputs("rst_mid");
    rst = 1'b1;
    model_reset();
    idle_cycles(1);
    cycle(1'b1, 16'hA000, 16'hB000, 1'b0, 1'b1, 1'b0);
    chk("rst_restart_acc", last_acc, 1);
    idle_cycles(5);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0));
    end
    idle_cycles(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
